// File: rtl/ob_drain_if.sv
// ob_drain_if: the output-buffer memory read port and the valid/ready word stream of ob_drain.
// master = the drain engine, slave = the memory and the downstream consumer.
interface ob_drain_if #(
    parameter int W  = 64,
    parameter int AW = 6
);
    logic          ob_mem_cenb_o;
    logic          ob_mem_wenb_o;
    logic [AW-1:0] ob_mem_addr_o;
    logic [W-1:0]  ob_mem_q_i;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;

    modport master (
        output ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, data_o, valid_o, last_o,
        input  ob_mem_q_i, ready_i
    );

    modport slave (
        input  ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, data_o, valid_o, last_o,
        output ob_mem_q_i, ready_i
    );
endinterface

// File: rtl/ob_drain.sv
// ob_drain: reads num_rows consecutive output-buffer words and streams them over valid/ready.
// Build macro OB_DRAIN_CHECKSUM_EN adds a running XOR checksum of the transferred words.
module ob_drain #(
    parameter int WIDTH  = 16,
    parameter int COL    = 4,
    parameter int O_SIZE = 64,
    localparam int W     = COL * WIDTH,
    localparam int AW    = $clog2(O_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_async_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   num_rows_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  checksum_o,
    ob_drain_if.master    bus
);
    localparam logic [1:0]    ST_IDLE   = 2'd0;
    localparam logic [1:0]    ST_RUN    = 2'd1;
    localparam logic [1:0]    ST_DONE   = 2'd2;
    localparam logic [AW:0]   ROW_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST = AW'(O_SIZE - 1);

    logic [1:0]    state_q, state_d;
    logic          cenb_q, cenb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rows_q, rows_d;
    logic [AW:0]   iss_q, iss_d;
    logic [AW:0]   xfer_cnt_q, xfer_cnt_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          valid_s, xfer_s, last_s, pop_s, store_s;
    logic [W-1:0]  data_s;
    logic [1:0]    slot_s;
    logic [2:0]    held_s;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == ADDR_LAST) begin
            return {AW{1'b0}};
        end else begin
            return a + {{(AW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Output side: the oldest buffered word, else the word returning from memory this cycle.
    always_comb begin
        valid_s = 1'b0;
        data_s  = {W{1'b0}};
        if (cnt_q != 2'd0) begin
            valid_s = 1'b1;
            data_s  = buf0_q;
        end else if (rvalid_q) begin
            valid_s = 1'b1;
            data_s  = bus.ob_mem_q_i;
        end else begin
            valid_s = 1'b0;
            data_s  = {W{1'b0}};
        end
        xfer_s = valid_s && bus.ready_i;
        last_s = valid_s && (xfer_cnt_q == (rows_q - ROW_ONE));
    end

    // Control FSM, read issue and address generation. A read is issued only if the buffer
    // will still have room next cycle, counting the word the current read brings back.
    always_comb begin
        state_d    = state_q;
        cenb_d     = 1'b1;
        addr_d     = addr_q;
        rows_d     = rows_q;
        iss_d      = iss_q;
        xfer_cnt_d = xfer_cnt_q;
        held_s     = {1'b0, cnt_q} + {2'b00, rvalid_q} + {2'b00, ~cenb_q} - {2'b00, xfer_s};
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rows_d     = num_rows_i;
                    addr_d     = base_addr_i;
                    xfer_cnt_d = {(AW+1){1'b0}};
                    if (num_rows_i != {(AW+1){1'b0}}) begin
                        state_d = ST_RUN;
                        cenb_d  = 1'b0;
                        iss_d   = ROW_ONE;
                    end else begin
                        state_d = ST_DONE;
                        iss_d   = {(AW+1){1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!cenb_q) begin
                    addr_d = next_addr(addr_q);
                end else begin
                    addr_d = addr_q;
                end
                if (xfer_s) begin
                    xfer_cnt_d = xfer_cnt_q + ROW_ONE;
                end else begin
                    xfer_cnt_d = xfer_cnt_q;
                end
                if (xfer_s && last_s) begin
                    state_d = ST_DONE;
                end else if ((held_s < 3'd2) && (iss_q < rows_q)) begin
                    cenb_d = 1'b0;
                    iss_d  = iss_q + ROW_ONE;
                end else begin
                    cenb_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Two-entry buffer: a returning word is captured unless it leaves straight away.
    always_comb begin
        rvalid_d = ~cenb_q;
        pop_s    = xfer_s && (cnt_q != 2'd0);
        store_s  = rvalid_q && !(xfer_s && (cnt_q == 2'd0));
        slot_s   = cnt_q - {1'b0, pop_s};
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        if (pop_s) begin
            buf0_d = buf1_q;
        end else begin
            buf0_d = buf0_q;
        end
        if (store_s) begin
            if (slot_s == 2'd0) begin
                buf0_d = bus.ob_mem_q_i;
            end else begin
                buf1_d = bus.ob_mem_q_i;
            end
        end else begin
            buf1_d = buf1_q;
        end
        cnt_d = cnt_q - {1'b0, pop_s} + {1'b0, store_s};
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            state_q    <= ST_IDLE;
            cenb_q     <= 1'b1;
            addr_q     <= {AW{1'b0}};
            rows_q     <= {(AW+1){1'b0}};
            iss_q      <= {(AW+1){1'b0}};
            xfer_cnt_q <= {(AW+1){1'b0}};
            rvalid_q   <= 1'b0;
            cnt_q      <= 2'd0;
            buf0_q     <= {W{1'b0}};
            buf1_q     <= {W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cenb_q     <= cenb_d;
            addr_q     <= addr_d;
            rows_q     <= rows_d;
            iss_q      <= iss_d;
            xfer_cnt_q <= xfer_cnt_d;
            rvalid_q   <= rvalid_d;
            cnt_q      <= cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef OB_DRAIN_CHECKSUM_EN
    logic [W-1:0] csum_q, csum_d;

    function automatic logic [W-1:0] csum_fold(input logic [W-1:0] acc, input logic [W-1:0] word);
        return acc ^ word;
    endfunction

    // Checksum clears on start acceptance and holds after the drain until the next start.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && start_i) begin
            csum_d = {W{1'b0}};
        end else if (xfer_s) begin
            csum_d = csum_fold(csum_q, data_s);
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            csum_q <= {W{1'b0}};
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = {W{1'b0}};
`endif

    assign bus.ob_mem_cenb_o = cenb_q;
    assign bus.ob_mem_wenb_o = 1'b1;
    assign bus.ob_mem_addr_o = addr_q;
    assign bus.data_o        = data_s;
    assign bus.valid_o       = valid_s;
    assign bus.last_o        = last_s;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
endmodule

// File: tb/tb_ob_drain.sv
// tb_ob_drain: directed bench for ob_drain with a synchronous-read memory model and a
// word-order scoreboard; checksum expectations follow OB_DRAIN_CHECKSUM_EN.
module tb_ob_drain;
    localparam int WIDTH  = 16;
    localparam int COL    = 1;
    localparam int O_SIZE = 64;
    localparam int W      = WIDTH * COL;
    localparam int AW     = $clog2(O_SIZE);

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   nrows;
    logic          busy;
    logic          done;
    logic [W-1:0]  csum;

    ob_drain_if #(.W(W), .AW(AW)) bus ();

    ob_drain #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
        .clk_i       (clk),
        .rst_async_i (rst),
        .start_i     (start),
        .base_addr_i (base),
        .num_rows_i  (nrows),
        .busy_o      (busy),
        .done_o      (done),
        .checksum_o  (csum),
        .bus         (bus)
    );

    logic [W-1:0]  mem [O_SIZE];
    logic [AW-1:0] rd_log [256];
    int            rd_cnt = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data for the strobed address appears after the edge.
    always @(posedge clk) begin
        if (!bus.ob_mem_cenb_o) begin
            bus.ob_mem_q_i          <= mem[bus.ob_mem_addr_o];
            rd_log[rd_cnt % 256]    <= bus.ob_mem_addr_o;
            rd_cnt                  <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_cenb"},  32'(bus.ob_mem_cenb_o), 32'd1);
        check({pfx, "_wenb"},  32'(bus.ob_mem_wenb_o), 32'd1);
        check({pfx, "_addr"},  32'(bus.ob_mem_addr_o), 32'd0);
        check({pfx, "_valid"}, 32'(bus.valid_o),       32'd0);
        check({pfx, "_last"},  32'(bus.last_o),        32'd0);
        check({pfx, "_busy"},  32'(busy),              32'd0);
        check({pfx, "_done"},  32'(done),              32'd0);
        check({pfx, "_data"},  32'(bus.data_o),        32'd0);
        check({pfx, "_csum"},  32'(csum),              32'd0);
    endtask

    // ready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1 from cycle 1.
    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
    endfunction

    task automatic drain(input int b, input int n, input int mode, input bit poke);
        int           idx, cyc, first_v, done_cyc, rd0;
        logic [W-1:0] cs, w, exp_cs;
        idx = 0; first_v = -1; done_cyc = -1; cs = {W{1'b0}}; cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; base = AW'(b); nrows = (AW+1)'(n); bus.ready_i = 1'b0;
        rd0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; bus.ready_i = rdy(mode, 1);
        while (cyc < 200 && done_cyc < 0) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (cyc == 1 && n > 0) begin
                    check("strobe_c1", 32'(bus.ob_mem_cenb_o), 32'd0);
                    check("addr_c1", 32'(bus.ob_mem_addr_o), 32'(b));
                end
                if (bus.valid_o && first_v < 0) first_v = cyc;
                if (idx < n) begin
                    if (bus.valid_o) begin
                        w = mem[(b + idx) % O_SIZE];
                        check("data", 32'(bus.data_o), 32'(w));
                        check("last", 32'(bus.last_o), 32'(idx == n - 1));
                        if (bus.ready_i) begin
                            cs = cs ^ w;
                            idx++;
                        end
                    end
                end else begin
                    check("no_extra_valid", 32'(bus.valid_o), 32'd0);
                end
                @(posedge clk); #1;
                cyc++;
                bus.ready_i = rdy(mode, cyc);
                if (poke) begin
                    start = (cyc == 3);
                    if (cyc == 3) begin
                        base = AW'(5); nrows = (AW+1)'(1);
                    end
                end
            end
        end
`ifdef OB_DRAIN_CHECKSUM_EN
        exp_cs = cs;
`else
        exp_cs = {W{1'b0}};
`endif
        check("done_seen", 32'(done_cyc > 0), 32'd1);
        check("words", 32'(idx), 32'(n));
        check("reads", 32'(rd_cnt - rd0), 32'(n));
        for (int i = 0; i < n; i++) check("rd_addr", 32'(rd_log[(rd0 + i) % 256]), 32'((b + i) % O_SIZE));
        if (n > 0) check("first_valid", 32'(first_v), 32'd2);
        if (mode == 0) check("done_cycle", 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n + 2));
        check("busy_in_done", 32'(busy), 32'd1);
        check("valid_in_done", 32'(bus.valid_o), 32'd0);
        check("csum_at_done", 32'(csum), 32'(exp_cs));
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = {AW{1'b0}}; nrows = {(AW+1){1'b0}}; bus.ready_i = 1'b0;
        for (int k = 0; k < O_SIZE; k++) mem[k] = W'(k + 1);
        #1;
        check_reset("por");
        @(posedge clk); #1;
        rst = 1'b0;

        drain(0, 4, 0, 1'b0);       // basic stream 1,2,3,4
        drain(62, 4, 0, 1'b0);      // address wrap 62,63,0,1
        drain(0, 8, 1, 1'b1);       // backpressure plus ignored start mid-drain
        drain(0, 0, 0, 1'b0);       // empty drain
        drain(7, 1, 1, 1'b0);       // single word

        // Reset after the third transfer of an eight-word drain.
        @(posedge clk); #1;
        start = 1'b1; base = AW'(0); nrows = (AW+1)'(8); bus.ready_i = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_no_done", 32'(done), 32'd0);
        drain(0, 2, 0, 1'b0);

        mem[20] = 16'h0001; mem[21] = 16'h0010; mem[22] = 16'h0100;
        drain(20, 3, 0, 1'b0);
`ifdef OB_DRAIN_CHECKSUM_EN
        check("csum_hold", 32'(csum), 32'h0000_0111);
`else
        check("csum_hold", 32'(csum), 32'h0000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ob_drain.md
OB_DRAIN -- requirements
Module: ob_drain

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one output element.
REQ-002 Parameter COL, default 4, elements per output-buffer word; word width W = COL*WIDTH.
REQ-003 Parameter O_SIZE, default 64, output-buffer depth in words; AW = $clog2(O_SIZE).
REQ-004 Port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_async_i, input, 1, reset, asynchronous and active-high.
REQ-006 Port start_i, input, 1, single-cycle drain request.
REQ-007 Port base_addr_i, input, AW, first word address; sampled when start_i is accepted.
REQ-008 Port num_rows_i, input, AW+1, number of words to drain; sampled when start_i is accepted.
REQ-009 Port ob_mem_cenb_o, input-side chip enable to memory, output, 1, active-low read strobe.
REQ-010 Port ob_mem_wenb_o, output, 1, write enable, constant 1 (read only).
REQ-011 Port ob_mem_addr_o, output, AW, read address.
REQ-012 Port ob_mem_q_i, input, W, read data, valid the cycle after the strobe.
REQ-013 Port data_o, output, W, streamed word.
REQ-014 Port valid_o, output, 1, data_o valid.
REQ-015 Port ready_i, input, 1, downstream accept; transfer occurs when valid_o and ready_i are both high.
REQ-016 Port last_o, output, 1, high with the final word of a drain.
REQ-017 Port busy_o, output, 1, high from start acceptance until done.
REQ-018 Port done_o, output, 1, one-cycle pulse when the drain completes.
REQ-019 Port checksum_o, output, W, running XOR of transferred words (see Configuration).

Function
REQ-020 States: IDLE, RUN, DONE. IDLE->RUN on start_i with num_rows_i != 0. IDLE->DONE on start_i with num_rows_i == 0. RUN->DONE on the transfer that has last_o high. DONE->IDLE unconditionally after 1 cycle.
REQ-021 start_i shall be ignored outside IDLE.
REQ-022 In RUN, issue a read (ob_mem_cenb_o=0) only when words in flight plus words held in the output buffer is < 2 and issued count < num_rows.
REQ-023 Output buffer shall be 2 entries deep. A returned read word enters it the cycle after issue. No word is dropped or duplicated under any ready_i pattern.
REQ-024 Read address shall start at base_addr and increment by 1 per issue, wrapping from O_SIZE-1 to 0.
REQ-025 Latency: start_i accepted at edge 0 -> first read issued in cycle 1 -> valid_o high in cycle 2.
REQ-026 With ready_i held high, throughput shall be 1 word/cycle: N words complete in N+2 cycles after start.
REQ-027 data_o and last_o shall hold stable while valid_o=1 and ready_i=0.
REQ-028 done_o shall pulse in the DONE cycle. busy_o is high in RUN and DONE.
REQ-029 ob_mem_cenb_o=1 in IDLE and DONE, and whenever no read is issued.

Reset
REQ-030 Asserting rst_async_i shall immediately force the following: state IDLE, ob_mem_cenb_o=1, ob_mem_wenb_o=1, ob_mem_addr_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, data_o=0, checksum_o=0, buffer empty, counters 0.
REQ-031 Reset mid-drain shall abandon the drain with no done_o pulse. The first start_i after reset release starts a fresh drain.

Configuration
REQ-032 With macro OB_DRAIN_CHECKSUM_EN defined:
- checksum_o clears on start acceptance.
- checksum_o XOR-accumulates each transferred word.
- checksum_o holds its value from DONE until the next start.
REQ-033 Without OB_DRAIN_CHECKSUM_EN, checksum_o shall be constant 0 and no accumulator logic shall exist.

Verification
REQ-034 Drain base=0, N=4, memory word k = k+1, ready_i=1:
- Stream is 1,2,3,4 in cycles 2-5.
- last_o is high with 4.
- done_o pulses in cycle 6.
REQ-035 Wrap: O_SIZE=64, base=62, N=4 -> read addresses are 62,63,0,1, in order.
REQ-036 Backpressure: N=8 with ready_i toggling 1,0,0,1 repeatedly -> 8 words in order, none lost, data_o stable while stalled.
REQ-037 num_rows_i=0 -> no memory strobe, done_o pulses 1 cycle after start, valid_o stays 0.
REQ-038 rst_async_i asserted after the 3rd transfer of N=8 -> all outputs at reset values immediately, no done_o. A new N=2 drain then completes correctly.
REQ-039 With OB_DRAIN_CHECKSUM_EN, words 0x0001,0x0010,0x0100 (WIDTH=16, COL=1) -> checksum_o=0x0111 at done. Without the macro, checksum_o=0.
